// File: rtl/sgbus_pkg.sv
// sgbus stream payload types shared by the stream router blocks.
package sgbus_pkg;

  localparam int unsigned DataW = 32;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  typedef logic [DataW-1:0] axis_data_t;

  // Header beat layout; pkt_len counts payload beats after the header.
  typedef struct packed {
    logic [7:0]  dst_id;
    logic [7:0]  pkt_id;
    logic [15:0] pkt_len;
  } sgbus_header_t;

  typedef struct packed {
    axis_data_t data;
  } axis_beat_t;

  typedef struct packed {
    logic       tvalid;
    axis_beat_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_resp_t;

endpackage

// File: rtl/sgbus_stream_arb.sv
// Packet-atomic N:1 round-robin arbiter for sgbus streams on the tx path.
// A grant is locked for one whole packet (header + pkt_len payload beats).
// Optional macro SGBUS_ARB_PRIO_EN: slave 0 wins every arbitration it requests,
// the other slaves rotate among themselves.
module sgbus_stream_arb #(
  parameter type         axis_req_t  = sgbus_pkg::axis_req_t,
  parameter type         axis_resp_t = sgbus_pkg::axis_resp_t,
  parameter type         axis_data_t = sgbus_pkg::axis_data_t,
  parameter int unsigned SlaveNum    = 2,
  parameter int unsigned MaxPayload  = 128
) (
  input  logic                                        stream_clk,
  input  logic                                        reset,
  input  axis_req_t                                   s_axis_req_i  [SlaveNum],
  output axis_resp_t                                  s_axis_resp_o [SlaveNum],
  output axis_req_t                                   m_axis_req_o,
  input  axis_resp_t                                  m_axis_resp_i,
  output logic [sgbus_pkg::idx_width(SlaveNum)-1:0]   grant_idx_o,
  output logic                                        busy_o,
  output logic                                        len_err_o
);

  localparam int unsigned IdxW = sgbus_pkg::idx_width(SlaveNum);
  localparam int unsigned CntW = sgbus_pkg::idx_width(MaxPayload) + 1;

  typedef enum logic {StIdle, StLock} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         grant_q;
  logic [IdxW-1:0]         last_grant_q;
  logic                    busy_q;
  logic                    len_err_q;
  logic                    hdr_seen_q;
  logic [CntW-1:0]         rem_q;

  logic [SlaveNum-1:0]     req_valid;
  logic                    win_found;
  logic [IdxW-1:0]         win_idx;
  int unsigned             cand;
  axis_req_t               sel_req;
  axis_data_t              sel_data;
  sgbus_pkg::sgbus_header_t sel_hdr;
  logic [15:0]             hdr_len;
  logic                    len_over;
  logic [CntW-1:0]         rem_load_d;
  logic                    hs;
  logic                    pkt_end;
  logic                    unused_hdr;

  // Decode the locked slave's beat as a header candidate.
  assign sel_req    = s_axis_req_i[grant_q];
  assign sel_data   = sel_req.t.data;
  assign sel_hdr    = sgbus_pkg::sgbus_header_t'(sel_data);
  assign hdr_len    = sel_hdr.pkt_len;
  assign unused_hdr = ^{sel_hdr.dst_id, sel_hdr.pkt_id};
  assign len_over   = 32'(hdr_len) > MaxPayload;
  assign rem_load_d = len_over ? CntW'(MaxPayload) : CntW'(hdr_len);

  assign hs      = (state_q == StLock) && sel_req.tvalid && m_axis_resp_i.tready;
  assign pkt_end = hs && (hdr_seen_q ? (rem_q == CntW'(1)) : (hdr_len == 16'd0));

  // Collect request valids into a vector.
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < int'(SlaveNum); i++) begin
      req_valid[i] = s_axis_req_i[i].tvalid;
    end
  end

  // Pick the next winner, scanning forward from the slave after last_grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
`ifdef SGBUS_ARB_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
    end
`endif
    for (int unsigned k = 1; k <= SlaveNum; k++) begin
      cand = (32'(last_grant_q) + k) % SlaveNum;
`ifdef SGBUS_ARB_PRIO_EN
      if (!win_found && (cand != 0) && req_valid[IdxW'(cand)]) begin
`else
      if (!win_found && req_valid[IdxW'(cand)]) begin
`endif
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  // Arbitration / packet-lock state machine with registered status outputs.
  always_ff @(posedge stream_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(SlaveNum - 1);
      busy_q       <= 1'b0;
      len_err_q    <= 1'b0;
      hdr_seen_q   <= 1'b0;
      rem_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StLock;
            grant_q <= win_idx;
            busy_q  <= 1'b1;
          end
        end
        StLock: begin
          if (hs) begin
            if (!hdr_seen_q) begin
              hdr_seen_q <= 1'b1;
              rem_q      <= rem_load_d;
              if (len_over) begin
                len_err_q <= 1'b1;
              end
            end else begin
              rem_q <= rem_q - CntW'(1);
            end
            if (pkt_end) begin
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              last_grant_q <= grant_q;
              hdr_seen_q   <= 1'b0;
              rem_q        <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency pass-through between the locked slave and the egress.
  always_comb begin
    m_axis_req_o = '0;
    for (int i = 0; i < int'(SlaveNum); i++) begin
      s_axis_resp_o[i] = '0;
    end
    if (state_q == StLock) begin
      m_axis_req_o           = sel_req;
      s_axis_resp_o[grant_q] = m_axis_resp_i;
    end
  end

  assign grant_idx_o = grant_q;
  assign busy_o      = busy_q;
  assign len_err_o   = len_err_q;

endmodule
